// File: rtl/store_unit.sv
// rtl/store_unit.sv - memory-stage store sequencer issuing byte/half/word stores as word-aligned beats
// Optional feature macro: STORE_MISALIGNED_EN (split word-crossing stores into two beats).
module store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        busy
`ifndef STORE_MISALIGNED_EN
  ,
  output logic        misaligned_exc
`endif
);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t      state, state_next;
  logic        mem_valid_next;
  logic [31:0] mem_addr_next, mem_wdata_next;
  logic [3:0]  mem_be_next;

  logic [1:0]  sh;
  logic [3:0]  mask;
  logic [31:0] data_mask, data_m, wide_lo;
  logic [7:0]  wide_be;
  logic        crossing, final_beat, accept;

  assign sh = req_addr[1:0];

  always_comb begin
    case (req_size)
      2'd0:    mask = 4'h1;
      2'd1:    mask = 4'h3;
      default: mask = 4'hF;
    endcase
  end

  // Mask off unused upper bytes so lanes outside mem_be are always zero.
  assign data_mask = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
  assign data_m    = req_data & data_mask;
  assign wide_be   = {4'b0000, mask} << sh;
  assign wide_lo   = data_m << {sh, 3'b000};
  assign crossing  = |wide_be[7:4];

`ifdef STORE_MISALIGNED_EN
  logic [31:0] wide_hi;
  logic [31:0] b1_addr, b1_addr_next, b1_data, b1_data_next;
  logic [3:0]  b1_be, b1_be_next;
  logic        need_b1, need_b1_next;

  // A shift of 32 (sh == 0) yields zero, so aligned stores never need beat 1.
  assign wide_hi    = data_m >> (6'd32 - {1'b0, sh, 3'b000});
  assign final_beat = (state == BEAT0 && !need_b1) || (state == BEAT1);
`else
  logic misaligned_exc_next;

  assign final_beat = (state == BEAT0);
`endif

  assign req_ready = !halt && (state == IDLE || (final_beat && mem_ready));
  assign accept    = req_valid && req_ready;
  assign busy      = (state != IDLE);

  always_comb begin
    state_next     = state;
    mem_valid_next = mem_valid;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    mem_be_next    = mem_be;
`ifdef STORE_MISALIGNED_EN
    b1_addr_next   = b1_addr;
    b1_data_next   = b1_data;
    b1_be_next     = b1_be;
    need_b1_next   = need_b1;
`else
    misaligned_exc_next = halt ? misaligned_exc : 1'b0;
`endif
    if (!halt) begin
      case (state)
        BEAT0: begin
          if (mem_ready) begin
`ifdef STORE_MISALIGNED_EN
            if (need_b1) begin
              state_next     = BEAT1;
              mem_addr_next  = b1_addr;
              mem_wdata_next = b1_data;
              mem_be_next    = b1_be;
            end else
`endif
            begin
              state_next     = IDLE;
              mem_valid_next = 1'b0;
            end
          end
        end
`ifdef STORE_MISALIGNED_EN
        BEAT1: begin
          if (mem_ready) begin
            state_next     = IDLE;
            mem_valid_next = 1'b0;
          end
        end
`endif
        default: ;
      endcase

      // An accept overrides the retire path above, giving back-to-back beats.
      if (accept) begin
`ifndef STORE_MISALIGNED_EN
        if (crossing) begin
          state_next          = IDLE;
          mem_valid_next      = 1'b0;
          misaligned_exc_next = 1'b1;
        end else
`endif
        begin
          state_next     = BEAT0;
          mem_valid_next = 1'b1;
          mem_addr_next  = {req_addr[31:2], 2'b00};
          mem_wdata_next = wide_lo;
          mem_be_next    = wide_be[3:0];
`ifdef STORE_MISALIGNED_EN
          need_b1_next   = crossing;
          b1_addr_next   = {req_addr[31:2] + 30'd1, 2'b00};
          b1_data_next   = wide_hi;
          b1_be_next     = wide_be[7:4];
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'h0;
`ifdef STORE_MISALIGNED_EN
      b1_addr   <= 32'h0;
      b1_data   <= 32'h0;
      b1_be     <= 4'h0;
      need_b1   <= 1'b0;
`else
      misaligned_exc <= 1'b0;
`endif
    end else begin
      state     <= state_next;
      mem_valid <= mem_valid_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      mem_be    <= mem_be_next;
`ifdef STORE_MISALIGNED_EN
      b1_addr   <= b1_addr_next;
      b1_data   <= b1_data_next;
      b1_be     <= b1_be_next;
      need_b1   <= need_b1_next;
`else
      misaligned_exc <= misaligned_exc_next;
`endif
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - scoreboard bench for store_unit (both STORE_MISALIGNED_EN builds)
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halt = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_data = 32'h0;
  logic        mem_valid;
  logic        mem_ready = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        busy;
  logic        misaligned_exc;

  store_unit dut (
    .clk(clk), .rst(rst), .halt(halt),
    .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
    .req_addr(req_addr), .req_data(req_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .busy(busy)
`ifndef STORE_MISALIGNED_EN
    , .misaligned_exc(misaligned_exc)
`endif
  );

`ifdef STORE_MISALIGNED_EN
  assign misaligned_exc = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] d;
  } beat_t;

  beat_t exp_q[$];
  int n_tests = 0;
  int n_fail = 0;
  int busy_cycles = 0;
  int handshakes = 0;
  int exc_cycles = 0;

  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr, prev_data;
  logic [3:0]  prev_be;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    beat_t b;
    b.a = a; b.be = be; b.d = d;
    exp_q.push_back(b);
  endtask

  // Monitor: beat scoreboard, hold-stability check, cycle counters.
  always @(negedge clk) begin
    beat_t e;
    if (busy === 1'b1) busy_cycles++;
    if (!rst && misaligned_exc === 1'b1) exc_cycles++;
    if (!rst && prev_pend)
      chk(mem_valid === 1'b1 && mem_addr === prev_addr && mem_data_eq(prev_data) && mem_be === prev_be,
          "hold", {mem_addr, mem_wdata}, {prev_addr, prev_data});
    prev_pend = !rst && mem_valid === 1'b1 && !(mem_ready && !halt);
    prev_addr = mem_addr;
    prev_data = mem_wdata;
    prev_be   = mem_be;
    if (!rst && mem_valid === 1'b1 && mem_ready && !halt) begin
      handshakes++;
      if (exp_q.size() == 0) begin
        chk(1'b0, "unexpected_beat", {mem_addr, mem_wdata}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        chk(mem_addr === e.a && mem_be === e.be && mem_wdata === e.d, "beat",
            {mem_addr, mem_wdata}, {e.a, e.d});
        chk(mem_be === e.be, "beat_be", 64'(mem_be), 64'(e.be));
      end
    end
  end

  function automatic bit mem_data_eq(input logic [31:0] d);
    return mem_wdata === d;
  endfunction

  task automatic send(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, input bit keep);
    bit got = 1'b0;
    req_size = sz; req_addr = a; req_data = d; req_valid = 1'b1;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1'b1;
        @(posedge clk);
        #1;
      end
    end
    if (!keep) req_valid = 1'b0;
    chk(got, "accept", 64'(got), 64'd1);
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    for (int k = 0; k < 50 && !idle; k++) begin
      @(negedge clk);
      if (!busy) idle = 1'b1;
    end
    chk(idle, "idle_timeout", 64'(idle), 64'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, h0, e0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(mem_valid === 1'b0, "rst_valid", 64'(mem_valid), 64'd0);
    chk(mem_addr === 32'h0 && mem_wdata === 32'h0, "rst_addr_data", {mem_addr, mem_wdata}, 64'h0);
    chk(mem_be === 4'h0, "rst_be", 64'(mem_be), 64'h0);
    chk(busy === 1'b0 && req_ready === 1'b1, "rst_busy_ready", {busy, req_ready}, 64'h1);
`ifndef STORE_MISALIGNED_EN
    chk(misaligned_exc === 1'b0, "rst_exc", 64'(misaligned_exc), 64'd0);
`endif
    @(posedge clk);
    #1;

    // Aligned word
    b0 = busy_cycles;
    push(32'h100, 4'hF, 32'hDEADBEEF);
    send(2'd2, 32'h100, 32'hDEADBEEF, 1'b0);
    wait_idle();
    chk(busy_cycles - b0 == 1, "word_busy", 64'(busy_cycles - b0), 64'd1);

    // Byte / half lanes, with garbage above the store width
    push(32'h200, 4'h8, 32'hAB000000);
    send(2'd0, 32'h203, 32'h000000AB, 1'b0);
    wait_idle();
    push(32'h0, 4'h2, 32'h0000AB00);
    send(2'd0, 32'h1, 32'h123456AB, 1'b0);
    wait_idle();
    push(32'h0, 4'hC, 32'hBEEF0000);
    send(2'd1, 32'h2, 32'h1234BEEF, 1'b0);
    wait_idle();
    push(32'h10, 4'hF, 32'h0BADF00D);
    send(2'd3, 32'h10, 32'h0BADF00D, 1'b0);
    wait_idle();

    // Crossing word
    b0 = busy_cycles;
    e0 = exc_cycles;
`ifdef STORE_MISALIGNED_EN
    push(32'h100, 4'hE, 32'h22334400);
    push(32'h104, 4'h1, 32'h00000011);
    send(2'd2, 32'h101, 32'h11223344, 1'b0);
    wait_idle();
    chk(busy_cycles - b0 == 2, "cross_busy", 64'(busy_cycles - b0), 64'd2);
`else
    send(2'd2, 32'h101, 32'h11223344, 1'b0);
    @(negedge clk);
    chk(misaligned_exc === 1'b1 && mem_valid === 1'b0, "exc_pulse", {misaligned_exc, mem_valid}, 64'h2);
    @(negedge clk);
    chk(misaligned_exc === 1'b0, "exc_drop", 64'(misaligned_exc), 64'd0);
    wait_idle();
    chk(busy_cycles - b0 == 0, "cross_busy", 64'(busy_cycles - b0), 64'd0);
    chk(exc_cycles - e0 == 1, "exc_width", 64'(exc_cycles - e0), 64'd1);
`endif

    // Half at top of memory, beat0 stalled by 3 cycles of !mem_ready
    e0 = exc_cycles;
`ifdef STORE_MISALIGNED_EN
    push(32'hFFFFFFFC, 4'h8, 32'hEF000000);
    push(32'h00000000, 4'h1, 32'h000000BE);
    mem_ready = 1'b0;
    send(2'd1, 32'hFFFFFFFF, 32'h0000BEEF, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(mem_valid === 1'b1 && mem_addr === 32'hFFFFFFFC, "stall_beat0", {31'h0, mem_valid, mem_addr}, {32'h1, 32'hFFFFFFFC});
    end
    @(posedge clk);
    #1 mem_ready = 1'b1;
    wait_idle();
`else
    send(2'd1, 32'hFFFFFFFF, 32'h0000BEEF, 1'b0);
    wait_idle();
    chk(exc_cycles - e0 == 1, "exc_half", 64'(exc_cycles - e0), 64'd1);
`endif

    // Reset while a beat is waiting: the pending write is abandoned
`ifdef STORE_MISALIGNED_EN
    push(32'h300, 4'hC, 32'h77880000);
    send(2'd2, 32'h302, 32'h55667788, 1'b0);
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk);
    chk(mem_valid === 1'b1 && mem_addr === 32'h304 && mem_be === 4'h3, "beat1_wait",
        {mem_be, mem_addr}, {4'h3, 32'h304});
`else
    mem_ready = 1'b0;
    send(2'd2, 32'h500, 32'h12345678, 1'b0);
    @(negedge clk);
    chk(mem_valid === 1'b1 && mem_addr === 32'h500, "beat0_wait", {31'h0, mem_valid, mem_addr}, {32'h1, 32'h500});
`endif
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(mem_valid === 1'b0 && busy === 1'b0, "rst_abandon", {mem_valid, busy}, 64'h0);
    mem_ready = 1'b1;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;

    // Back-to-back aligned stores with a 2-cycle halt
    b0 = busy_cycles;
    h0 = handshakes;
    for (int i = 0; i < 6; i++) push(32'h400 + 32'(4 * i), 4'hF, 32'hA0000000 + 32'(i));
    for (int i = 0; i < 6; i++) begin
      send(2'd2, 32'h400 + 32'(4 * i), 32'hA0000000 + 32'(i), 1'b1);
      if (i == 2) begin
        halt = 1'b1;
        repeat (2) @(posedge clk);
        #1 halt = 1'b0;
      end
    end
    req_valid = 1'b0;
    wait_idle();
    chk(handshakes - h0 == 6, "burst_beats", 64'(handshakes - h0), 64'd6);
    chk(busy_cycles - b0 == 8, "burst_cycles", 64'(busy_cycles - b0), 64'd8);

    repeat (3) @(negedge clk);
    chk(exp_q.size() == 0, "leftover", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_unit.md
# store_unit

Memory-stage store sequencer for the Dioptase pipeline. It is the write-side counterpart of the writeback load merge. It accepts one store (byte, half or word) at an arbitrary byte address and issues it to the data memory port as one or two word-aligned writes with byte enables. Little-endian lane placement is used. A misaligned store that crosses a word boundary is split into two beats, and the pipeline is stalled until both beats are accepted.

## Interface
Parameters:
- none; address and data are fixed at 32 bits

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- halt  in  1  freezes all state and registered outputs while high
- req_valid  in  1  store request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_size  in  2  0 byte, 1 half, 2 word; 3 reserved, treated as word
- req_addr  in  32  byte address
- req_data  in  32  store data, right-justified
- mem_valid  out  1  write beat presented to memory
- mem_ready  in  1  memory accepts beat when mem_valid && mem_ready
- mem_addr  out  32  word-aligned address, bits [1:0] always 0
- mem_wdata  out  32  lane-aligned write data
- mem_be  out  4  byte enables, bit i covers mem_wdata[8i+7:8i]
- busy  out  1  high whenever state != IDLE; used as a pipeline stall
- misaligned_exc  out  1  one-cycle pulse; only exists in the configuration without `STORE_MISALIGNED_EN`

## Operation
- States: IDLE, BEAT0, BEAT1.
- Lane computation at acceptance, with sh = req_addr[1:0]:
  - mask = 1 (byte), 3 (half) or F (word).
  - wide_be[7:0] = mask << sh.
  - wide_data[63:0] = req_data << (8*sh).
- Beat 0: mem_addr = {req_addr[31:2],2'b00}, mem_be = wide_be[3:0], mem_wdata = wide_data[31:0].
- Beat 1 is needed iff wide_be[7:4] != 0. It uses mem_addr = beat0 addr + 4 (wraps FFFFFFFC→00000000), mem_be = wide_be[7:4], mem_wdata = wide_data[63:32]. Beat 1 values are latched at acceptance.
- Transitions:
  - IDLE → BEAT0 on accept.
  - BEAT0 → BEAT1 on mem_ready if beat 1 is needed, else → IDLE (or → BEAT0 on a back-to-back accept).
  - BEAT1 → IDLE on mem_ready, or → BEAT0 on a back-to-back accept.
- req_ready = !halt && (state==IDLE || (final beat && mem_ready)).
- Lanes outside mem_be carry 0 in mem_wdata.
- While mem_valid && !mem_ready, mem_addr, mem_wdata and mem_be hold stable. mem_valid never drops before acceptance.
- Reset: state IDLE, mem_valid 0, mem_addr 0, mem_wdata 0, mem_be 0, busy 0, misaligned_exc 0. Reset mid-operation abandons any pending beat with no further write.
- halt high: no state change, no accept, outputs held. A mem_ready seen during halt is ignored, so memory must re-accept after halt drops.

## Timing
- Registered outputs: the first beat appears on mem_valid the cycle after accept.
- Aligned or in-word store with mem_ready tied high: 1 mem cycle, busy for 1 cycle.
- Crossing store with mem_ready tied high: 2 consecutive mem cycles, busy for 2 cycles.
- Back-to-back accepts give 1 store/cycle for aligned traffic with no bubble on mem_valid.
- Each cycle mem_ready is low adds exactly one cycle to the current beat.

## Configuration
- `STORE_MISALIGNED_EN` defined: crossing stores are split into two beats as above.
- `STORE_MISALIGNED_EN` undefined: a request with wide_be[7:4] != 0 is still accepted (req_ready unchanged) but issues no memory beat. misaligned_exc pulses high for exactly one cycle, the cycle after accept, and state stays IDLE. BEAT1 logic is removed, and in-word stores behave identically to the enabled configuration.

## Test plan
- Word 0xDEADBEEF at 0x100, mem_ready=1 → one beat: addr 0x100, be F, wdata DEADBEEF; busy for 1 cycle.
- Byte 0x000000AB at 0x203 → addr 0x200, be 8, wdata AB000000; single beat.
- Word 0x11223344 at 0x101 → beat0 addr 0x100, be E, wdata 22334400; beat1 addr 0x104, be 1, wdata 00000011. Without the macro: no beats, misaligned_exc pulses one cycle.
- Half 0xBEEF at 0xFFFFFFFF, mem_ready low for 3 cycles on beat0 → beat0 held 4 cycles with addr FFFFFFFC, be 8, wdata EF000000. Then beat1 addr 00000000, be 1, wdata 000000BE.
- rst asserted during BEAT1 wait → next cycle mem_valid 0, busy 0, and no beat1 write ever observed.
- Aligned stores presented every cycle with halt pulsed high for 2 cycles → 1 beat/cycle outside halt; outputs frozen during halt; no store lost or duplicated.
